// File: rtl/riscv_pkg.sv
// riscv_pkg: shared constants and types for the instruction fetch front end
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  typedef enum logic {IDLE, RUN} fetch_state_e;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: power-of-2 circular buffer with flush, registered occupancy and head
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] head
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  always_comb begin
    wr_ptr_d = flush ? '0 : wr_ptr_q + AW'(push);
    rd_ptr_d = flush ? '0 : rd_ptr_q + AW'(pop);
    count_d = flush ? '0 : count_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr_q] <= din;
  end
  assign count = count_q;
  assign head = mem[rd_ptr_q];
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: decoupled instruction fetch with request throttling and redirect flush
module fetch_unit #(
  parameter int XLEN = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch_en,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [31:0]     if_instr,
  output logic [XLEN-1:0] pc_out
);
  import riscv_pkg::*;
  localparam int CW = $clog2(DEPTH) + 1;
  fetch_state_e state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d, target;
  logic [CW-1:0] outst_q, outst_d, drop_cnt_q, drop_cnt_d, count;
  logic [XLEN+31:0] head;
  logic req_fire, push, pop, keep;
  always_comb begin
    target = redirect_pc & ~XLEN'(3);
    // buffered plus in-flight never exceeds DEPTH, so the FIFO cannot overflow
    imem_req_valid = state_q == RUN && !redirect_valid
                     && {1'b0, count} + {1'b0, outst_q} < (CW+1)'(DEPTH);
    imem_req_addr = fetch_pc_q;
    req_fire = imem_req_valid && imem_req_ready;
    if_valid = count != '0;
    pop = if_valid && if_ready && !redirect_valid;
    keep = drop_cnt_q == '0;
    push = imem_rsp_valid && keep && !redirect_valid;
    state_d = fetch_en ? RUN : (imem_req_valid && !imem_req_ready) ? state_q : IDLE;
    fetch_pc_d = redirect_valid ? target : req_fire ? fetch_pc_q + XLEN'(4) : fetch_pc_q;
    rsp_pc_d = redirect_valid ? target : push ? rsp_pc_q + XLEN'(4) : rsp_pc_q;
    outst_d = outst_q + CW'(req_fire) - CW'(imem_rsp_valid);
    drop_cnt_d = redirect_valid ? outst_q - CW'(imem_rsp_valid)
                                : drop_cnt_q - CW'(imem_rsp_valid && !keep);
    if_pc = if_valid ? head[XLEN+31:32] : '0;
    if_instr = if_valid ? head[31:0] : NOP_INSTR;
    pc_out = fetch_pc_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      fetch_pc_q <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      outst_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q <= rsp_pc_d;
      outst_q <= outst_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end
  fetch_fifo #(.DEPTH(DEPTH), .WIDTH(XLEN + 32)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   ({rsp_pc_q, imem_rsp_data}),
    .count (count),
    .head  (head)
  );
endmodule
